// File: rtl/branch_pkg.sv
// Shared types for the gshare predictor access scheduler.
package branch_pkg;

   // One buffered resolution update waiting for the predictor port.
   typedef struct packed {
      logic [31:0] pc;
      logic        taken;
   } upd_entry_t;

   // Owner of the predictor port in a given cycle.
   typedef enum logic [1:0] {
      GRANT_IDLE,
      GRANT_LKUP,
      GRANT_UPD
   } grant_t;

endpackage

// File: rtl/branch_upd_queue.sv
// In-order circular FIFO of pending predictor updates.
module branch_upd_queue
   import branch_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enq,
   input  upd_entry_t             enq_data,
   input  logic                   deq,
   output upd_entry_t             head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned PW = $clog2(DEPTH);

   upd_entry_t        mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PW:0]       count_q, count_d;

   assign head  = mem_q[rd_ptr_q];
   assign full  = (count_q == (PW+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

   // Pointer and occupancy next state; pointers wrap at the power-of-two depth.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
      if (enq && !deq)      count_d = count_q + (PW+1)'(1);
      else if (!enq && deq) count_d = count_q - (PW+1)'(1);
   end

   // Control state with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; occupancy decides what is valid.
   always_ff @(posedge clk) begin
      if (enq) mem_q[wr_ptr_q] <= enq_data;
   end

endmodule

// File: rtl/branch_pred_sched.sv
// Arbitrates the single predictor port between fetch lookups and queued updates.
module branch_pred_sched
   import branch_pkg::*;
#(
   parameter int unsigned UPD_QUEUE_DEPTH = 4,
   parameter int unsigned MAX_DEFER       = 3
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             lkup_req_val,
   output logic                             lkup_req_rdy,
   input  logic [31:0]                      lkup_req_pc,
   output logic                             lkup_resp_val,
   input  logic                             lkup_resp_rdy,
   output logic                             lkup_resp_taken,
   input  logic                             upd_req_val,
   output logic                             upd_req_rdy,
   input  logic [31:0]                      upd_req_pc,
   input  logic                             upd_req_taken,
   output logic [31:0]                      bp_pc,
   output logic                             bp_update_en,
   output logic                             bp_update_val,
   input  logic                             bp_prediction,
   output logic [$clog2(UPD_QUEUE_DEPTH):0] upd_count
);

   localparam int unsigned DW = $clog2(MAX_DEFER + 1);
   localparam logic [DW-1:0] MaxDefer = DW'(MAX_DEFER);

   grant_t          grant;
   logic            lkup_ok;
   logic            q_full, q_empty, q_enq, q_deq;
   upd_entry_t      q_head, q_in;
   logic            resp_val_q, resp_val_d;
   logic            resp_taken_q, resp_taken_d;
   logic [DW-1:0]   defer_q, defer_d;

   assign q_in         = '{pc: upd_req_pc, taken: upd_req_taken};
   // No pass-through: a slot freed by this cycle's dequeue is not reusable yet.
   assign upd_req_rdy  = !reset && !q_full;
   assign q_enq        = upd_req_val && upd_req_rdy;
   assign q_deq        = (grant == GRANT_UPD);
   assign lkup_req_rdy = (grant == GRANT_LKUP);
   assign lkup_resp_val   = resp_val_q;
   assign lkup_resp_taken = resp_taken_q;

   branch_upd_queue #(
      .DEPTH (UPD_QUEUE_DEPTH)
   ) u_queue (
      .clk      (clk),
      .reset    (reset),
      .enq      (q_enq),
      .enq_data (q_in),
      .deq      (q_deq),
      .head     (q_head),
      .full     (q_full),
      .empty    (q_empty),
      .count    (upd_count)
   );

   // Grant selection: updates win when forced or when no lookup can proceed.
   always_comb begin
      lkup_ok = lkup_req_val && (!resp_val_q || lkup_resp_rdy);
      grant   = GRANT_IDLE;
      if (reset) begin
         grant = GRANT_IDLE;
      end else if (!q_empty && (q_full || defer_q == MaxDefer || !lkup_ok)) begin
         grant = GRANT_UPD;
      end else if (lkup_ok) begin
         grant = GRANT_LKUP;
      end
   end

   // Predictor port drive for the granted requester.
   always_comb begin
      bp_pc         = '0;
      bp_update_en  = 1'b0;
      bp_update_val = 1'b0;
      unique case (grant)
         GRANT_UPD: begin
            bp_pc         = q_head.pc;
            bp_update_en  = 1'b1;
            bp_update_val = q_head.taken;
         end
         GRANT_LKUP: bp_pc = lkup_req_pc;
         default: ;
      endcase
   end

   // Response register and defer counter next state.
   always_comb begin
      resp_val_d   = resp_val_q;
      resp_taken_d = resp_taken_q;
      if (grant == GRANT_LKUP) begin
         resp_val_d   = 1'b1;
         resp_taken_d = bp_prediction;
      end else if (resp_val_q && lkup_resp_rdy) begin
         resp_val_d = 1'b0;
      end
      defer_d = defer_q;
      if (grant == GRANT_UPD || q_empty) begin
         defer_d = '0;
      end else if (defer_q != MaxDefer) begin
         defer_d = defer_q + DW'(1);
      end
   end

   // Scheduler state with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         resp_val_q   <= 1'b0;
         resp_taken_q <= 1'b0;
         defer_q      <= '0;
      end else begin
         resp_val_q   <= resp_val_d;
         resp_taken_q <= resp_taken_d;
         defer_q      <= defer_d;
      end
   end

endmodule

// File: tb/tb_branch_pred_sched.sv
// Self-checking bench for branch_pred_sched against a queue-based reference model.
module tb_branch_pred_sched;

   localparam int unsigned Depth    = 4;
   localparam int unsigned MaxDefer = 3;
   localparam int unsigned CW       = $clog2(Depth) + 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          lkup_req_val = 1'b0, lkup_req_rdy;
   logic [31:0]   lkup_req_pc = '0;
   logic          lkup_resp_val, lkup_resp_rdy = 1'b0, lkup_resp_taken;
   logic          upd_req_val = 1'b0, upd_req_rdy;
   logic [31:0]   upd_req_pc = '0;
   logic          upd_req_taken = 1'b0;
   logic [31:0]   bp_pc;
   logic          bp_update_en, bp_update_val;
   logic          bp_prediction = 1'b0;
   logic [CW-1:0] upd_count;

   always #5 clk = ~clk;

   branch_pred_sched #(
      .UPD_QUEUE_DEPTH (Depth),
      .MAX_DEFER       (MaxDefer)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .lkup_req_val    (lkup_req_val),
      .lkup_req_rdy    (lkup_req_rdy),
      .lkup_req_pc     (lkup_req_pc),
      .lkup_resp_val   (lkup_resp_val),
      .lkup_resp_rdy   (lkup_resp_rdy),
      .lkup_resp_taken (lkup_resp_taken),
      .upd_req_val     (upd_req_val),
      .upd_req_rdy     (upd_req_rdy),
      .upd_req_pc      (upd_req_pc),
      .upd_req_taken   (upd_req_taken),
      .bp_pc           (bp_pc),
      .bp_update_en    (bp_update_en),
      .bp_update_val   (bp_update_val),
      .bp_prediction   (bp_prediction),
      .upd_count       (upd_count)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: pending updates as a plain queue, defer as an integer.
   typedef struct {
      logic [31:0] pc;
      logic        taken;
   } m_upd_t;
   m_upd_t mq[$];
   int     mdefer = 0;
   logic   mresp_val = 1'b0, mresp_taken = 1'b0;

   // Expected and observed values for the cycle just simulated.
   int          exp_grant;
   logic        exp_lkup_req_rdy, exp_upd_req_rdy, exp_upd_en, exp_upd_val;
   logic        exp_resp_val, exp_resp_taken;
   logic [31:0] exp_bp_pc;
   int          exp_count;
   logic        obs_lkup_req_rdy, obs_upd_req_rdy, obs_upd_en, obs_upd_val;
   logic        obs_resp_val, obs_resp_taken;
   logic [31:0] obs_bp_pc;
   logic [CW-1:0] obs_count;
   logic [1:0]  obs_defer;

   // 0 = idle, 1 = lookup, 2 = update
   function automatic int model_grant();
      logic lk_ok;
      lk_ok = lkup_req_val && (!mresp_val || lkup_resp_rdy);
      if (reset) return 0;
      if (mq.size() > 0 && (mq.size() == Depth || mdefer == MaxDefer || !lk_ok)) return 2;
      if (lk_ok) return 1;
      return 0;
   endfunction

   // Samples DUT and model on the falling edge, then advances the model at the rising edge.
   task automatic cycle();
      m_upd_t e;
      int     pre_size;
      @(negedge clk);
      exp_grant        = model_grant();
      exp_lkup_req_rdy = (exp_grant == 1);
      exp_upd_req_rdy  = !reset && (mq.size() < Depth);
      exp_upd_en       = (exp_grant == 2);
      exp_upd_val      = (exp_grant == 2) ? mq[0].taken : 1'b0;
      exp_bp_pc        = (exp_grant == 2) ? mq[0].pc : (exp_grant == 1) ? lkup_req_pc : 32'h0;
      exp_resp_val     = mresp_val;
      exp_resp_taken   = mresp_taken;
      exp_count        = mq.size();
      obs_lkup_req_rdy = lkup_req_rdy;
      obs_upd_req_rdy  = upd_req_rdy;
      obs_upd_en       = bp_update_en;
      obs_upd_val      = bp_update_val;
      obs_bp_pc        = bp_pc;
      obs_resp_val     = lkup_resp_val;
      obs_resp_taken   = lkup_resp_taken;
      obs_count        = upd_count;
      obs_defer        = dut.defer_q;
      @(posedge clk);
      if (reset) begin
         mq.delete();
         mdefer      = 0;
         mresp_val   = 1'b0;
         mresp_taken = 1'b0;
      end else begin
         pre_size = mq.size();
         if (exp_grant == 2) void'(mq.pop_front());
         if (upd_req_val && exp_upd_req_rdy) begin
            e.pc    = upd_req_pc;
            e.taken = upd_req_taken;
            mq.push_back(e);
         end
         if (exp_grant == 1) begin
            mresp_val   = 1'b1;
            mresp_taken = bp_prediction;
         end else if (mresp_val && lkup_resp_rdy) begin
            mresp_val = 1'b0;
         end
         if (exp_grant == 2 || pre_size == 0) mdefer = 0;
         else if (mdefer < MaxDefer) mdefer = mdefer + 1;
      end
      #1;
   endtask

   task automatic idle_inputs();
      lkup_req_val  = 1'b0;
      upd_req_val   = 1'b0;
      lkup_resp_rdy = 1'b1;
      bp_prediction = 1'b0;
   endtask

   task automatic drain();
      idle_inputs();
      for (int i = 0; i < 20 && (mq.size() != 0 || mresp_val); i++) cycle();
      cycle();
      n_checks++;
      if (obs_count !== 0 || obs_resp_val !== 1'b0) begin
         n_fail++;
         $display("FAIL drain: count=%0d resp_val=%b, required 0 and 0", obs_count, obs_resp_val);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      lkup_req_val = 1'b1;
      lkup_resp_rdy = 1'b1;
      upd_req_val = 1'b1;
      lkup_req_pc = 32'h40;
      upd_req_pc = 32'h80;
      for (int i = 0; i < 2; i++) begin
         cycle();
         n_checks++;
         if (obs_upd_req_rdy !== 1'b0 || obs_lkup_req_rdy !== 1'b0 || obs_upd_en !== 1'b0
             || obs_bp_pc !== 32'h0 || obs_upd_val !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: upd_rdy=%b lkup_rdy=%b en=%b pc=%h val=%b, required all 0",
                     obs_upd_req_rdy, obs_lkup_req_rdy, obs_upd_en, obs_bp_pc, obs_upd_val);
         end
      end
      reset = 1'b0;
      idle_inputs();
      cycle();
      n_checks++;
      if (obs_count !== 0 || obs_resp_val !== 1'b0 || obs_resp_taken !== 1'b0
          || obs_upd_req_rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_state: count=%0d rv=%b rt=%b upd_rdy=%b, required 0 0 0 1",
                  obs_count, obs_resp_val, obs_resp_taken, obs_upd_req_rdy);
      end
   endtask

   task automatic test_lookup();
      drain();
      lkup_req_val = 1'b1;
      lkup_req_pc = 32'h100;
      bp_prediction = 1'b1;
      lkup_resp_rdy = 1'b0;
      cycle();
      n_checks++;
      if (obs_bp_pc !== 32'h100 || obs_lkup_req_rdy !== 1'b1 || obs_upd_en !== 1'b0) begin
         n_fail++;
         $display("FAIL lookup_issue: pc=%h rdy=%b en=%b, required 100 1 0",
                  obs_bp_pc, obs_lkup_req_rdy, obs_upd_en);
      end
      lkup_req_pc = 32'h104;
      bp_prediction = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         n_checks++;
         if (obs_resp_val !== 1'b1 || obs_resp_taken !== 1'b1 || obs_lkup_req_rdy !== 1'b0
             || obs_bp_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL lookup_hold: rv=%b rt=%b rdy=%b pc=%h, required 1 1 0 0",
                     obs_resp_val, obs_resp_taken, obs_lkup_req_rdy, obs_bp_pc);
         end
      end
      lkup_req_val = 1'b0;
      lkup_resp_rdy = 1'b1;
      cycle();
      cycle();
      n_checks++;
      if (obs_resp_val !== 1'b0) begin
         n_fail++;
         $display("FAIL lookup_drain: resp_val=%b, required 0", obs_resp_val);
      end
   endtask

   task automatic test_update();
      drain();
      upd_req_val = 1'b1;
      upd_req_pc = 32'h200;
      upd_req_taken = 1'b1;
      cycle();
      n_checks++;
      if (obs_upd_en !== 1'b0 || obs_upd_req_rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL update_nobypass: en=%b rdy=%b, required 0 1", obs_upd_en, obs_upd_req_rdy);
      end
      upd_req_pc = 32'h204;
      upd_req_taken = 1'b0;
      cycle();
      n_checks++;
      if (obs_upd_en !== 1'b1 || obs_bp_pc !== 32'h200 || obs_upd_val !== 1'b1 || obs_count !== 1) begin
         n_fail++;
         $display("FAIL update_first: en=%b pc=%h val=%b cnt=%0d, required 1 200 1 1",
                  obs_upd_en, obs_bp_pc, obs_upd_val, obs_count);
      end
      upd_req_val = 1'b0;
      cycle();
      n_checks++;
      if (obs_upd_en !== 1'b1 || obs_bp_pc !== 32'h204 || obs_upd_val !== 1'b0 || obs_count !== 1) begin
         n_fail++;
         $display("FAIL update_second: en=%b pc=%h val=%b cnt=%0d, required 1 204 0 1",
                  obs_upd_en, obs_bp_pc, obs_upd_val, obs_count);
      end
      cycle();
      n_checks++;
      if (obs_upd_en !== 1'b0 || obs_count !== 0) begin
         n_fail++;
         $display("FAIL update_empty: en=%b cnt=%0d, required 0 0", obs_upd_en, obs_count);
      end
   endtask

   task automatic test_full();
      int seen_full = 0;
      drain();
      lkup_req_val = 1'b1;
      upd_req_val = 1'b1;
      for (int i = 0; i < 10; i++) begin
         lkup_req_pc = 32'h1000 + 32'(i);
         upd_req_pc = 32'h400 + 32'(4 * i);
         upd_req_taken = i[0];
         cycle();
         n_checks++;
         if (obs_bp_pc !== exp_bp_pc || obs_upd_en !== exp_upd_en) begin
            n_fail++;
            $display("FAIL full_port: pc=%h en=%b, required %h %b", obs_bp_pc, obs_upd_en,
                     exp_bp_pc, exp_upd_en);
         end
         if (obs_count == Depth) begin
            seen_full++;
            n_checks++;
            if (obs_upd_req_rdy !== 1'b0 || obs_upd_en !== 1'b1 || obs_lkup_req_rdy !== 1'b0) begin
               n_fail++;
               $display("FAIL full_priority: upd_rdy=%b en=%b lkup_rdy=%b, required 0 1 0",
                        obs_upd_req_rdy, obs_upd_en, obs_lkup_req_rdy);
            end
         end
      end
      n_checks++;
      if (seen_full < 1) begin
         n_fail++;
         $display("FAIL full_reached: full cycles=%0d, required at least 1", seen_full);
      end
   endtask

   task automatic test_starvation();
      int exp_seq[5] = '{1, 1, 1, 2, 1};
      int g;
      drain();
      upd_req_val = 1'b1;
      upd_req_pc = 32'h500;
      upd_req_taken = 1'b1;
      cycle();
      upd_req_val = 1'b0;
      lkup_req_val = 1'b1;
      for (int i = 0; i < 5; i++) begin
         lkup_req_pc = 32'h600 + 32'(i);
         cycle();
         g = obs_upd_en ? 2 : (obs_lkup_req_rdy ? 1 : 0);
         n_checks++;
         if (g !== exp_seq[i]) begin
            n_fail++;
            $display("FAIL starve_seq[%0d]: grant=%0d, required %0d", i, g, exp_seq[i]);
         end
         if (i == 4) begin
            n_checks++;
            if (obs_defer !== 2'd0) begin
               n_fail++;
               $display("FAIL starve_defer_clear: defer=%0d, required 0", obs_defer);
            end
         end
      end
   endtask

   task automatic test_wrap();
      drain();
      lkup_req_val = 1'b1;
      upd_req_val = 1'b1;
      for (int i = 0; i < 2; i++) begin
         upd_req_pc = 32'h300 + 32'(4 * i);
         upd_req_taken = i[0];
         cycle();
      end
      lkup_req_val = 1'b0;
      for (int k = 0; k < 14; k++) begin
         upd_req_val = (k < 12);
         upd_req_pc = 32'h300 + 32'(4 * (k + 2));
         upd_req_taken = k[0];
         cycle();
         n_checks++;
         if (obs_upd_en !== 1'b1 || obs_bp_pc !== 32'h300 + 32'(4 * k) || obs_upd_val !== k[0]) begin
            n_fail++;
            $display("FAIL wrap_order[%0d]: en=%b pc=%h val=%b, required 1 %h %b", k, obs_upd_en,
                     obs_bp_pc, obs_upd_val, 32'h300 + 32'(4 * k), k[0]);
         end
         if (k < 12) begin
            n_checks++;
            if (obs_count !== 2) begin
               n_fail++;
               $display("FAIL wrap_count[%0d]: count=%0d, required 2", k, obs_count);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      drain();
      lkup_req_val = 1'b1;
      upd_req_val = 1'b1;
      bp_prediction = 1'b1;
      for (int i = 0; i < 3; i++) begin
         upd_req_pc = 32'h700 + 32'(4 * i);
         cycle();
      end
      idle_inputs();
      lkup_resp_rdy = 1'b0;
      reset = 1'b1;
      cycle();
      n_checks++;
      if (obs_count !== 3 || obs_resp_val !== 1'b1 || obs_upd_en !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_pre: cnt=%0d rv=%b en=%b, required 3 1 0",
                  obs_count, obs_resp_val, obs_upd_en);
      end
      reset = 1'b0;
      cycle();
      n_checks++;
      if (obs_count !== 0 || obs_resp_val !== 1'b0 || obs_resp_taken !== 1'b0 || obs_upd_en !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_post: cnt=%0d rv=%b rt=%b en=%b, required 0 0 0 0",
                  obs_count, obs_resp_val, obs_resp_taken, obs_upd_en);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         reset         = ($urandom_range(0, 59) == 0);
         lkup_req_val  = $urandom_range(0, 3) != 0;
         lkup_req_pc   = $urandom;
         lkup_resp_rdy = $urandom_range(0, 2) != 0;
         upd_req_val   = $urandom_range(0, 1) != 0;
         upd_req_pc    = $urandom;
         upd_req_taken = $urandom_range(0, 1) != 0;
         bp_prediction = $urandom_range(0, 1) != 0;
         cycle();
         n_checks++;
         if (obs_lkup_req_rdy !== exp_lkup_req_rdy || obs_upd_req_rdy !== exp_upd_req_rdy
             || obs_upd_en !== exp_upd_en || obs_upd_val !== exp_upd_val || obs_bp_pc !== exp_bp_pc
             || obs_resp_val !== exp_resp_val || obs_resp_taken !== exp_resp_taken
             || obs_count !== exp_count) begin
            n_fail++;
            $display("FAIL random[%0d]: lr=%b ur=%b en=%b v=%b pc=%h rv=%b rt=%b c=%0d, required lr=%b ur=%b en=%b v=%b pc=%h rv=%b rt=%b c=%0d",
                     i, obs_lkup_req_rdy, obs_upd_req_rdy, obs_upd_en, obs_upd_val, obs_bp_pc,
                     obs_resp_val, obs_resp_taken, obs_count, exp_lkup_req_rdy, exp_upd_req_rdy,
                     exp_upd_en, exp_upd_val, exp_bp_pc, exp_resp_val, exp_resp_taken, exp_count);
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_lookup();
      test_update();
      test_full();
      test_starvation();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
